seq_mul8x8_ctrl: RTL and testbench
==================================

# seq_mul8x8_ctrl

Sequential 8x8 unsigned multiplier controller that time-multiplexes one external 4x4 unsigned array multiplier. It sits directly upstream and downstream of that array: it drives the array's 4-bit operand inputs with nibble pairs, consumes the array's 8-bit product, and accumulates four shifted partial products into a 16-bit result. A valid/ready handshake is used on both the operand side and the result side.

## Interface
- PIPE_Z, default 0: 0 = accumulate `mul_z` in the same cycle it is driven; 1 = register `mul_z` first and accumulate one cycle later.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- a  in  8  multiplicand, unsigned
- b  in  8  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  16  product a*b
- busy  out  1  high in any state other than IDLE
- mul_x  out  4  operand X to the 4x4 array
- mul_y  out  4  operand Y to the 4x4 array
- mul_z  in  8  product from the 4x4 array (combinational from mul_x/mul_y)

## Operation
- States:
  - IDLE: accepting operands.
  - MUL: 2-bit step counter k = 0..3.
  - DRAIN: exists only when PIPE_Z=1.
  - DONE: presenting the result.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b; clear the accumulator; set k=0; go to MUL.
- MUL step operands, with aL/aH and bL/bH the low/high nibbles:
  - k=0: (mul_x, mul_y) = (aL, bL), shift 0
  - k=1: (aH, bL), shift 4
  - k=2: (aL, bH), shift 4
  - k=3: (aH, bH), shift 8
- Accumulation:
  - acc += zero-extended mul_z, shifted as above.
  - Width is 16 bits; the sum never exceeds 0xFE01, so no overflow or carry-out handling.
- PIPE_Z=0: accumulate in the same cycle as the step. After k=3, go to DONE.
- PIPE_Z=1:
  - Register mul_z and its shift each MUL cycle; add on the following cycle.
  - After k=3, go to DRAIN (final add), then DONE.
- DONE:
  - out_valid=1; p=acc, held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
- in_ready=0 in MUL, DRAIN and DONE. in_valid outside IDLE is ignored; no operand queuing.
- mul_x and mul_y:
  - Combinational decode of state, k and the captured operands.
  - 0 in IDLE, DRAIN and DONE.
- Captured a and b are immune to input changes after acceptance.

## Timing
- Reset (async assert, synchronous-safe deassert): state=IDLE, in_ready=1, out_valid=0, p=0, busy=0, mul_x=0, mul_y=0, acc=0, k=0.
- Reset mid-operation: abort immediately. No out_valid is produced; the next operation starts clean.
- Handshake in cycle 0:
  - MUL occupies cycles 1-4.
  - PIPE_Z=0: out_valid rises in cycle 5.
  - PIPE_Z=1: DRAIN in cycle 5, out_valid rises in cycle 6.
- Back-to-back: out_ready held high gives one result per 6 cycles (PIPE_Z=0), since a new in_valid is accepted no earlier than the cycle after the DONE handshake.
- out_valid and p do not change while out_ready=0.

## Configuration
- SEQMUL_ZERO_SKIP_EN, defined:
  - On acceptance with a==0 or b==0, go directly from IDLE to DONE with acc=0.
  - out_valid rises in cycle 1; mul_x and mul_y stay 0.
- SEQMUL_ZERO_SKIP_EN, undefined: zero operands take the full MUL sequence with normal latency.

## Test plan
- a=0xFF, b=0xFF, out_ready=1, PIPE_Z=0 -> p=0xFE01, out_valid in cycle 5, then IDLE with in_ready=1 in cycle 6.
- a=0xA7, b=0x3C -> (mul_x, mul_y) in cycles 1-4 = (7,C), (A,C), (7,3), (A,3); p=0x2724. Repeat with PIPE_Z=1: same p, out_valid in cycle 6.
- a=0x12, b=0x34, out_ready held low 3 cycles after out_valid -> p=0x03A8 stable throughout, a single handshake, in_ready low until it completes.
- Accept a=0x55, b=0x55; assert rst_n=0 in cycle 2 -> all outputs at reset values immediately. Next op a=0x03, b=0x04 -> p=0x000C.
- a=0x00, b=0x5A -> p=0x0000: out_valid in cycle 1 with SEQMUL_ZERO_SKIP_EN, cycle 5 without.
- in_valid with a=0x99 toggled during MUL -> ignored; the original result is delivered unchanged.

Source files
------------

// File: rtl/seq_mul8x8_ctrl.sv
// seq_mul8x8_ctrl
// ---------------
// Sequential 8x8 unsigned multiplier controller. It reuses one external,
// purely combinational 4x4 unsigned array multiplier for four nibble steps,
// accumulates the shifted partial products into a 16-bit result, and returns
// the result over a valid/ready handshake.
//
// Parameter:
//   PIPE_Z  0: mul_z is added in the same cycle it is produced.
//           1: mul_z and its shift are registered, then added one cycle later.
//              A DRAIN state performs the last add.
//
// Optional feature (compile-time macro SEQMUL_ZERO_SKIP_EN):
//   When defined, an accepted operand pair with a==0 or b==0 goes straight
//   from IDLE to DONE with a zero result. The array is never driven.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   controller can accept operands (IDLE only)
//   a, b       in   8   unsigned operands
//   out_valid  out  1   product valid (DONE only)
//   out_ready  in   1   consumer accepts product
//   p          out  16  product a*b
//   busy       out  1   high in any state other than IDLE
//   mul_x      out  4   operand X to the 4x4 array
//   mul_y      out  4   operand Y to the 4x4 array
//   mul_z      in   8   product from the 4x4 array, combinational from mul_x/mul_y
//
// Handshake rule, on both sides: a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and data stable
// until that transfer. in_valid outside IDLE is ignored; nothing is queued.

module seq_mul8x8_ctrl #(
  parameter bit PIPE_Z = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy,
  output logic [3:0]  mul_x,
  output logic [3:0]  mul_y,
  input  logic [7:0]  mul_z
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [7:0]  z_q;
  logic [3:0]  sh_q;
  logic [3:0]  shift;
  logic        accept;
  logic        zero_op;
  logic [15:0] term_now;
  logic [15:0] term_reg;

`ifdef SEQMUL_ZERO_SKIP_EN
  assign zero_op = (a == 8'h00) || (b == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  assign accept   = in_valid & in_ready;
  assign p        = acc;
  assign busy     = (state != S_IDLE);
  assign term_now = {8'h00, mul_z} << shift;
  assign term_reg = {8'h00, z_q} << sh_q;

  // Next state, handshake outputs and the array operand decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_x     = 4'h0;
    mul_y     = 4'h0;
    shift     = 4'd0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = zero_op ? S_DONE : S_MUL;
      end
      S_MUL: begin
        // Step order: aL*bL, aH*bL, aL*bH, aH*bH.
        mul_x = k[0] ? a_q[7:4] : a_q[3:0];
        mul_y = k[1] ? b_q[7:4] : b_q[3:0];
        case (k)
          2'd0:    shift = 4'd0;
          2'd3:    shift = 4'd8;
          default: shift = 4'd4;
        endcase
        if (k == 2'd3) state_nxt = PIPE_Z ? S_DRAIN : S_DONE;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      acc   <= 16'h0000;
      z_q   <= 8'h00;
      sh_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        acc  <= 16'h0000;
        k    <= 2'd0;
        z_q  <= 8'h00;
        sh_q <= 4'd0;
      end else if (state == S_MUL) begin
        k <= k + 2'd1;
        if (PIPE_Z) begin
          // z_q is cleared on accept, so the first add here contributes zero.
          acc  <= acc + term_reg;
          z_q  <= mul_z;
          sh_q <= shift;
        end else begin
          acc <= acc + term_now;
        end
      end else if (state == S_DRAIN) begin
        acc <= acc + term_reg;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul8x8_ctrl.sv
// Bench for seq_mul8x8_ctrl. Two instances run side by side on the same
// stimulus, one with PIPE_Z=0 and one with PIPE_Z=1. Each instance has its
// own behavioural 4x4 array. Expected values are taken from plain
// arithmetic and the cycle timeline of the design.
module tb_seq_mul8x8_ctrl;

`ifdef SEQMUL_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a_i = 8'h00;
  logic [7:0]  b_i = 8'h00;
  logic        out_ready = 1'b0;

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [15:0] p_w         [2];
  logic        busy_w      [2];
  logic [3:0]  mul_x_w     [2];
  logic [3:0]  mul_y_w     [2];
  logic [7:0]  mul_z_w     [2];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  // Behavioural 4x4 arrays
  assign mul_z_w[0] = mul_x_w[0] * mul_y_w[0];
  assign mul_z_w[1] = mul_x_w[1] * mul_y_w[1];

  seq_mul8x8_ctrl #(.PIPE_Z(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a_i), .b(b_i), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .p(p_w[0]), .busy(busy_w[0]), .mul_x(mul_x_w[0]), .mul_y(mul_y_w[0]),
    .mul_z(mul_z_w[0])
  );

  seq_mul8x8_ctrl #(.PIPE_Z(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a_i), .b(b_i), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .p(p_w[1]), .busy(busy_w[1]), .mul_x(mul_x_w[1]), .mul_y(mul_y_w[1]),
    .mul_z(mul_z_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_in_ready%0d", tag, d),  {31'd0, in_ready_w[d]},  32'd1);
      check($sformatf("%s_out_valid%0d", tag, d), {31'd0, out_valid_w[d]}, 32'd0);
      check($sformatf("%s_p%0d", tag, d),         {16'd0, p_w[d]},         32'd0);
      check($sformatf("%s_busy%0d", tag, d),      {31'd0, busy_w[d]},      32'd0);
      check($sformatf("%s_mulxy%0d", tag, d),
            {24'd0, mul_x_w[d], mul_y_w[d]}, 32'd0);
    end
  endtask

  // One operation. rel is the first cycle (after the accept cycle 0) in which
  // out_ready is high. When toggle is set, in_valid and the operand inputs are
  // disturbed while the multiplier is stepping.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input int rel, input bit toggle);
    int lat [2];
    int hs  [2];
    int win;
    bit skip;
    logic [15:0] exp_p;
    logic [7:0] pair;
    skip  = SKIP_EN && ((av == 8'h00) || (bv == 8'h00));
    exp_p = 16'(av) * 16'(bv);
    exp_q.delete();
    exp_q.push_back({av[3:0], bv[3:0]});
    exp_q.push_back({av[7:4], bv[3:0]});
    exp_q.push_back({av[3:0], bv[7:4]});
    exp_q.push_back({av[7:4], bv[7:4]});
    lat[0] = skip ? 1 : 5;
    lat[1] = skip ? 1 : 6;
    for (int d = 0; d < 2; d++) hs[d] = (rel > lat[d]) ? rel : lat[d];
    win = ((hs[0] > hs[1]) ? hs[0] : hs[1]) + 1;

    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("idle_ready%0d", d), {31'd0, in_ready_w[d]}, 32'd1);
    a_i = av; b_i = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (toggle && c <= 4) begin
        in_valid = 1'($urandom_range(0, 1));
        a_i = 8'h99; b_i = 8'h99;
      end else begin
        in_valid = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom);
      end
      out_ready = (c >= rel);
      #1;
      for (int d = 0; d < 2; d++) begin
        pair = (!skip && c <= 4) ? exp_q[c-1] : 8'h00;
        check($sformatf("mulxy%0d_c%0d", d, c), {24'd0, mul_x_w[d], mul_y_w[d]}, {24'd0, pair});
        check($sformatf("out_valid%0d_c%0d", d, c), {31'd0, out_valid_w[d]},
              {31'd0, (c >= lat[d]) && (c <= hs[d])});
        check($sformatf("in_ready%0d_c%0d", d, c), {31'd0, in_ready_w[d]},
              {31'd0, c > hs[d]});
        check($sformatf("busy%0d_c%0d", d, c), {31'd0, busy_w[d]},
              {31'd0, c <= hs[d]});
        if (c >= lat[d] && c <= hs[d])
          check($sformatf("p%0d_c%0d", d, c), {16'd0, p_w[d]}, {16'd0, exp_p});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'hFF, 8'hFF, 1, 1'b0);
    do_op(8'hA7, 8'h3C, 1, 1'b0);
    do_op(8'h12, 8'h34, 8, 1'b0);
    do_op(8'h00, 8'h5A, 1, 1'b0);
    do_op(8'h5A, 8'h00, 2, 1'b0);
    do_op(8'h21, 8'h43, 1, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    a_i = 8'h55; b_i = 8'h55; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h03, 8'h04, 1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (($urandom_range(0, 7)) == 0) ra = 8'h00;
      if (($urandom_range(0, 7)) == 0) rb = 8'h00;
      do_op(ra, rb, $urandom_range(1, 9), (ra != 8'h00) && (rb != 8'h00) && ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
